fpu_host_initiator: RTL and testbench

//  CPU-side initiator for the FPU core's start/done/ack command handshake.
//  Sol-1 loads operands and the opcode byte-wise over the 8-bit bus; this block issues the command,

---
 rtl/fpu_host_initiator_if.sv | 27 ++
 rtl/fpu_host_initiator.sv | 146 ++++++++++++++
 tb/tb_fpu_host_initiator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_host_initiator_if.sv
// CPU byte-bus and FPU start/done/ack handshake signals for the FPU host initiator.
// master is the initiator's view; slave is the CPU/core side.
interface fpu_host_initiator_if;
  logic        cs;
  logic        wr;
  logic [3:0]  addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        irq;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_start;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic        fpu_ack;

  modport master (
    input  cs, wr, addr, data_in, fpu_done, fpu_result,
    output data_out, irq, fpu_op, fpu_a, fpu_b, fpu_start, fpu_ack
  );

  modport slave (
    output cs, wr, addr, data_in, fpu_done, fpu_result,
    input  data_out, irq, fpu_op, fpu_a, fpu_b, fpu_start, fpu_ack
  );
endinterface

// File: rtl/fpu_host_initiator.sv
// CPU-side initiator for the FPU core: byte-wide operand/opcode registers, four-phase
// start/done/ack command handshake with timeout, result capture, status flags and irq.
module fpu_host_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic                 clk,
  input logic                 arst,
  fpu_host_initiator_if.master bus
);
  localparam int unsigned           CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]            OP_MAX   = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       a_q, b_q, result_q;
  logic [3:0]        op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              start_q, ack_q;
  logic              busy_q, done_q, err_op_q, err_tmo_q, err_busy_q, irq_en_q;

  logic              wr_en, operand_wr, cmd_wr, stat_wr, ctrl_wr, in_idle;
  logic              blocked_wr, cmd_go, cmd_bad;
  logic              capture, tmo, ack_to_done, done_set;
  logic [7:0]        status, rd_byte;

  // Bus write decode; operand/command writes are only honoured while idle
  always_comb begin
    wr_en      = bus.cs & bus.wr;
    in_idle    = (state_q == S_IDLE);
    operand_wr = wr_en & ~bus.addr[3];
    cmd_wr     = wr_en & (bus.addr == 4'hC);
    stat_wr    = wr_en & (bus.addr == 4'hD);
    ctrl_wr    = wr_en & (bus.addr == 4'hE);
    blocked_wr = (operand_wr | cmd_wr) & ~in_idle;
    cmd_go     = cmd_wr & in_idle & (bus.data_in[3:0] <= OP_MAX);
    cmd_bad    = cmd_wr & in_idle & (bus.data_in[3:0] >  OP_MAX);
  end

  // FSM state register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state and per-cycle event strobes
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    tmo         = 1'b0;
    ack_to_done = 1'b0;
    done_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_go) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.fpu_done) begin
          capture = 1'b1;
          state_d = S_ACK;
        end else if (cnt_q == CNT_LAST) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        if (!bus.fpu_done) begin
          ack_to_done = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        done_set = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs, timeout counter and datapath registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      start_q  <= 1'b0;
      ack_q    <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      irq_en_q <= 1'b0;
    end else begin
      start_q <= (state_d == S_REQ);
      ack_q   <= (state_d == S_ACK);
      if (cmd_go)                 cnt_q <= '0;
      else if (state_q == S_REQ)  cnt_q <= cnt_q + CNT_W'(1);
      if (operand_wr && in_idle) begin
        if (bus.addr[2]) b_q[{bus.addr[1:0], 3'b000} +: 8] <= bus.data_in;
        else             a_q[{bus.addr[1:0], 3'b000} +: 8] <= bus.data_in;
      end
      if (cmd_go)  op_q     <= bus.data_in[3:0];
      if (capture) result_q <= bus.fpu_result;
      if (ctrl_wr) irq_en_q <= bus.data_in[0];
    end
  end

  // Status flags: write-1-to-clear, with a same-cycle set taking priority
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_op_q   <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_busy_q <= 1'b0;
    end else begin
      if (cmd_go)                   busy_q <= 1'b1;
      else if (tmo || ack_to_done)  busy_q <= 1'b0;
      done_q     <= done_set   | (done_q     & ~(stat_wr & bus.data_in[1]) & ~cmd_go);
      err_busy_q <= blocked_wr | (err_busy_q & ~(stat_wr & bus.data_in[2]));
      err_tmo_q  <= tmo        | (err_tmo_q  & ~(stat_wr & bus.data_in[3]));
      err_op_q   <= cmd_bad    | (err_op_q   & ~(stat_wr & bus.data_in[4]));
    end
  end

  // Combinational read mux
  always_comb begin
    status  = {3'b000, err_op_q, err_tmo_q, err_busy_q, done_q, busy_q};
    rd_byte = 8'h00;
    case (bus.addr)
      4'h0, 4'h1, 4'h2, 4'h3: rd_byte = a_q[{bus.addr[1:0], 3'b000} +: 8];
      4'h4, 4'h5, 4'h6, 4'h7: rd_byte = b_q[{bus.addr[1:0], 3'b000} +: 8];
      4'h8, 4'h9, 4'hA, 4'hB: rd_byte = result_q[{bus.addr[1:0], 3'b000} +: 8];
      4'hD:                   rd_byte = status;
      4'hE:                   rd_byte = {7'b0000000, irq_en_q};
      default:                rd_byte = 8'h00;
    endcase
  end

  assign bus.data_out  = bus.cs ? rd_byte : 8'h00;
  assign bus.irq       = irq_en_q & (done_q | err_op_q | err_tmo_q | err_busy_q);
  assign bus.fpu_op    = op_q;
  assign bus.fpu_a     = a_q;
  assign bus.fpu_b     = b_q;
  assign bus.fpu_start = start_q;
  assign bus.fpu_ack   = ack_q;
endmodule

// File: tb/tb_fpu_host_initiator.sv
// Directed bench for fpu_host_initiator: CPU register access, handshake timing,
// timeout, busy rejection, async reset abort and extended done hold.
module tb_fpu_host_initiator;
  logic clk = 1'b0;
  logic arst;
  int   n_cmp = 0;
  int   n_bad = 0;

  fpu_host_initiator_if bif ();

  fpu_host_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bif.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    bif.cs = 1'b1; bif.wr = 1'b1; bif.addr = a; bif.data_in = d;
    tick();
    bif.cs = 1'b0; bif.wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    bif.cs = 1'b1; bif.wr = 1'b0; bif.addr = a;
    #1;
    d = bif.data_out;
    bif.cs = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    cpu_rd(a, d);
    chk(tag, 32'(d), 32'(exp));
  endtask

  initial begin
    int hi;
    bif.cs = 1'b0; bif.wr = 1'b0; bif.addr = 4'h0; bif.data_in = 8'h00;
    bif.fpu_done = 1'b0; bif.fpu_result = 32'h0;
    arst = 1'b1;
    tick();
    chk("rst_start", 32'(bif.fpu_start), 32'd0);
    chk("rst_ack",   32'(bif.fpu_ack),   32'd0);
    chk("rst_irq",   32'(bif.irq),       32'd0);
    chk("rst_a",     bif.fpu_a,          32'h0);
    chk_rd("rst_status", 4'hD, 8'h00);
    arst = 1'b0;
    tick();

    // 1: 1.0 + 2.0 = 3.0
    cpu_wr(4'h0, 8'h00); cpu_wr(4'h1, 8'h00); cpu_wr(4'h2, 8'h80); cpu_wr(4'h3, 8'h3F);
    cpu_wr(4'h4, 8'h00); cpu_wr(4'h5, 8'h00); cpu_wr(4'h6, 8'h00); cpu_wr(4'h7, 8'h40);
    cpu_wr(4'hE, 8'h01);
    chk("t1_a", bif.fpu_a, 32'h3F800000);
    chk("t1_b", bif.fpu_b, 32'h40000000);
    chk_rd("t1_ctrl", 4'hE, 8'h01);
    chk_rd("t1_regf", 4'hF, 8'h00);
    cpu_wr(4'hC, 8'h00);
    chk("t1_start_n1", 32'(bif.fpu_start), 32'd1);
    chk_rd("t1_busy", 4'hD, 8'h01);
    for (int i = 0; i < 4; i++) tick();
    chk("t1_start_hold", 32'(bif.fpu_start), 32'd1);
    bif.fpu_done = 1'b1; bif.fpu_result = 32'h40400000;
    tick();
    chk("t1_ack_m1",   32'(bif.fpu_ack),   32'd1);
    chk("t1_start_m1", 32'(bif.fpu_start), 32'd0);
    tick();
    chk("t1_ack_hold", 32'(bif.fpu_ack), 32'd1);
    bif.fpu_done = 1'b0; bif.fpu_result = 32'hDEADBEEF;
    tick();
    chk("t1_ack_k1", 32'(bif.fpu_ack), 32'd0);
    chk_rd("t1_stat_k1", 4'hD, 8'h00);
    tick();
    chk_rd("t1_stat_k2", 4'hD, 8'h02);
    chk("t1_irq", 32'(bif.irq), 32'd1);
    chk_rd("t1_r0", 4'h8, 8'h00);
    chk_rd("t1_r1", 4'h9, 8'h00);
    chk_rd("t1_r2", 4'hA, 8'h40);
    chk_rd("t1_r3", 4'hB, 8'h40);

    // 2: illegal opcode
    cpu_wr(4'hC, 8'h0E);
    chk_rd("t2_errop", 4'hD, 8'h12);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (bif.fpu_start) hi++;
      tick();
    end
    chk("t2_no_start", 32'(hi), 32'd0);
    cpu_wr(4'hD, 8'h10);
    chk_rd("t2_clr_errop", 4'hD, 8'h02);
    cpu_wr(4'hD, 8'h02);
    chk_rd("t2_clr_done", 4'hD, 8'h00);
    chk("t2_irq_low", 32'(bif.irq), 32'd0);

    // 3: timeout
    cpu_wr(4'hC, 8'h02);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (bif.fpu_start) hi++;
      tick();
    end
    chk("t3_start_cycles", 32'(hi), 32'd16);
    chk_rd("t3_errtmo", 4'hD, 8'h08);
    chk("t3_irq", 32'(bif.irq), 32'd1);
    cpu_wr(4'hD, 8'h08);
    chk_rd("t3_clr", 4'hD, 8'h00);

    // 4: writes while busy are dropped
    cpu_wr(4'hC, 8'h01);
    chk("t4_start", 32'(bif.fpu_start), 32'd1);
    cpu_wr(4'h0, 8'h55);
    cpu_wr(4'hC, 8'h03);
    chk_rd("t4_errbusy", 4'hD, 8'h05);
    chk("t4_a_kept",  bif.fpu_a, 32'h3F800000);
    chk("t4_op_kept", 32'(bif.fpu_op), 32'd1);
    bif.fpu_done = 1'b1; bif.fpu_result = 32'h12345678;
    tick();
    chk("t4_ack", 32'(bif.fpu_ack), 32'd1);
    bif.fpu_done = 1'b0;
    tick();
    tick();
    chk_rd("t4_stat", 4'hD, 8'h06);
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (bif.fpu_start) hi++;
      tick();
    end
    chk("t4_one_txn", 32'(hi), 32'd0);
    chk_rd("t4_r0", 4'h8, 8'h78);
    cpu_wr(4'hD, 8'h06);

    // 5: async reset while in ACK
    cpu_wr(4'hC, 8'h00);
    bif.fpu_done = 1'b1; bif.fpu_result = 32'hCAFEBABE;
    tick();
    chk("t5_in_ack", 32'(bif.fpu_ack), 32'd1);
    #2 arst = 1'b1;
    #1;
    chk("t5_ack_rst",   32'(bif.fpu_ack),   32'd0);
    chk("t5_start_rst", 32'(bif.fpu_start), 32'd0);
    chk("t5_a_rst",     bif.fpu_a,          32'h0);
    chk_rd("t5_stat_rst", 4'hD, 8'h00);
    chk_rd("t5_res_rst",  4'hB, 8'h00);
    bif.fpu_done = 1'b0;
    tick();
    arst = 1'b0;
    tick();

    // 6: done held past ack; stray done in idle
    cpu_wr(4'hC, 8'h00);
    bif.fpu_done = 1'b1; bif.fpu_result = 32'h11223344;
    tick();
    bif.fpu_result = 32'h99999999;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_ack_held", 32'(bif.fpu_ack), 32'd1);
    end
    bif.fpu_done = 1'b0;
    tick();
    chk("t6_ack_drop", 32'(bif.fpu_ack), 32'd0);
    tick();
    chk_rd("t6_stat", 4'hD, 8'h02);
    chk_rd("t6_r0", 4'h8, 8'h44);
    chk_rd("t6_r3", 4'hB, 8'h11);
    bif.fpu_done = 1'b1; bif.fpu_result = 32'h77777777;
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bif.fpu_ack) hi++;
    end
    bif.fpu_done = 1'b0;
    chk("t6_stray_noack", 32'(hi), 32'd0);
    chk_rd("t6_stray_res", 4'h8, 8'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
